// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared encodings, write-queue entry type and AXI sizing helpers
package bridge_pkg;

    localparam logic [2:0] TYPE_BYTE = 3'd0;
    localparam logic [2:0] TYPE_HALF = 3'd1;
    localparam logic [2:0] TYPE_WORD = 3'd2;
    localparam logic [2:0] TYPE_LINE = 3'd4;

    // Entries are sized for the largest supported line; narrower lines use the low bits.
    localparam int MAX_LINE_WIDTH = 512;

    typedef struct packed {
        logic [31:0]               addr;
        logic [2:0]                typ;
        logic [3:0]                wstrb;
        logic [MAX_LINE_WIDTH-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } wstate_t;

    // Bit position of the line address inside a byte address.
    function automatic int line_ofs(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic logic [7:0] axi_len(input logic [2:0] t, input int line_words);
        return (t == TYPE_LINE) ? 8'(line_words - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] axi_size(input logic [2:0] t);
        return (t == TYPE_LINE) ? 3'd2 : t;
    endfunction

endpackage

// File: rtl/axi_wr_queue.sv
// rtl/axi_wr_queue.sv - circular posted-write FIFO exposing per-entry addresses for hazard checks
module axi_wr_queue
    import bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  wr_entry_t              i_entry,
    input  logic                   i_pop,
    output wr_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [DEPTH-1:0]       o_valid,
    output logic [DEPTH-1:0][31:0] o_addr
);

    localparam int PW = $clog2(DEPTH);

    wr_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    // Pointer and occupancy update; storage is written on push only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_entry;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - r_rptr;
            o_valid[i] = ({1'b0, off} < r_count);
            o_addr[i]  = r_mem[i].addr;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/axi_bridge_mp.sv
// rtl/axi_bridge_mp.sv - multi-port AXI3 master: round-robin reads by ID, posted write queue
module axi_bridge_mp
    import bridge_pkg::*;
#(
    parameter int NUM_RD     = 2,
    parameter int LINE_WORDS = 4,
    parameter int WQ_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [3:0]               o_arid,
    output logic [31:0]              o_araddr,
    output logic [7:0]               o_arlen,
    output logic [2:0]               o_arsize,
    output logic [1:0]               o_arburst,
    output logic [1:0]               o_arlock,
    output logic [3:0]               o_arcache,
    output logic [2:0]               o_arprot,
    output logic                     o_arvalid,
    input  logic                     i_arready,
    input  logic [3:0]               i_rid,
    input  logic [31:0]              i_rdata,
    input  logic [1:0]               i_rresp,
    input  logic                     i_rlast,
    input  logic                     i_rvalid,
    output logic                     o_rready,
    output logic [3:0]               o_awid,
    output logic [31:0]              o_awaddr,
    output logic [7:0]               o_awlen,
    output logic [2:0]               o_awsize,
    output logic [1:0]               o_awburst,
    output logic [1:0]               o_awlock,
    output logic [3:0]               o_awcache,
    output logic [2:0]               o_awprot,
    output logic                     o_awvalid,
    input  logic                     i_awready,
    output logic [3:0]               o_wid,
    output logic [31:0]              o_wdata,
    output logic [3:0]               o_wstrb,
    output logic                     o_wlast,
    output logic                     o_wvalid,
    input  logic                     i_wready,
    input  logic [3:0]               i_bid,
    input  logic [1:0]               i_bresp,
    input  logic                     i_bvalid,
    output logic                     o_bready,
    input  logic [NUM_RD-1:0]        i_rd_req,
    input  logic [3*NUM_RD-1:0]      i_rd_type,
    input  logic [32*NUM_RD-1:0]     i_rd_addr,
    output logic [NUM_RD-1:0]        o_rd_rdy,
    output logic [NUM_RD-1:0]        o_ret_valid,
    output logic [NUM_RD-1:0]        o_ret_last,
    output logic [31:0]              o_ret_data,
    input  logic                     i_wr_req,
    input  logic [2:0]               i_wr_type,
    input  logic [31:0]              i_wr_addr,
    input  logic [3:0]               i_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] i_wr_data,
    output logic                     o_wr_rdy,
    output logic                     o_write_buffer_empty
);

    localparam int OFS = line_ofs(LINE_WORDS);

    // ---------------- write queue ----------------
    wr_entry_t                w_push_entry;
    wr_entry_t                w_head;
    logic                     w_q_full;
    logic                     w_q_empty;
    logic [WQ_DEPTH-1:0]      w_q_valid;
    logic [WQ_DEPTH-1:0][31:0] w_q_addr;
    logic                     w_push;
    logic                     w_pop;

    // Pack the incoming write into a queue entry.
    always_comb begin
        w_push_entry       = '0;
        w_push_entry.addr  = i_wr_addr;
        w_push_entry.typ   = i_wr_type;
        w_push_entry.wstrb = i_wr_wstrb;
        w_push_entry.data  = MAX_LINE_WIDTH'(i_wr_data);
    end

    assign w_push = i_wr_req && !w_q_full;

    axi_wr_queue #(.DEPTH(WQ_DEPTH)) u_wq (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_valid (w_q_valid),
        .o_addr  (w_q_addr)
    );

    assign o_wr_rdy             = !w_q_full;
    assign o_write_buffer_empty = w_q_empty;

    // ---------------- read arbitration ----------------
    logic [NUM_RD-1:0] r_pend;
    logic [NUM_RD-1:0] w_hazard;
    logic [NUM_RD-1:0] w_elig;
    logic [3:0]        r_rr;
    logic [3:0]        w_win;
    logic              w_any;
    logic [31:0]       w_win_addr;
    logic [2:0]        w_win_type;
    logic              w_ar_free;
    logic              r_arvalid;
    logic [3:0]        r_arid;
    logic [31:0]       r_araddr;
    logic [7:0]        r_arlen;
    logic [2:0]        r_arsize;

    assign w_ar_free = !r_arvalid || i_arready;

    // Line-granular hazard against every live queue entry and the write entering this cycle.
    always_comb begin
        w_hazard = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int j = 0; j < WQ_DEPTH; j++) begin
                if (w_q_valid[j] && (w_q_addr[j][OFS +: 32-OFS] == i_rd_addr[32*i+OFS +: 32-OFS]))
                    w_hazard[i] = 1'b1;
            end
            if (w_push && (i_wr_addr[OFS +: 32-OFS] == i_rd_addr[32*i+OFS +: 32-OFS]))
                w_hazard[i] = 1'b1;
        end
    end

    // Round-robin pick: the eligible port closest at or after the pointer wins.
    always_comb begin
        int best;
        int d;
        best       = NUM_RD;
        d          = 0;
        w_any      = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        w_win_type = '0;
        w_elig     = '0;
        o_rd_rdy   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_elig[i] = i_rd_req[i] && !r_pend[i] && !w_hazard[i] && w_ar_free;
            d = i - int'(r_rr);
            if (d < 0) d = d + NUM_RD;
            if (w_elig[i] && (d < best)) begin
                best       = d;
                w_any      = 1'b1;
                w_win      = 4'(i);
                w_win_addr = i_rd_addr[32*i +: 32];
                w_win_type = i_rd_type[3*i +: 3];
            end
        end
        for (int i = 0; i < NUM_RD; i++) begin
            o_rd_rdy[i] = w_any && (w_win == 4'(i));
        end
    end

    // AR register: load on grant, hold until arready, advance the RR pointer past the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_rr      <= '0;
        end else if (w_any) begin
            r_arvalid <= 1'b1;
            r_arid    <= w_win;
            r_araddr  <= w_win_addr;
            r_arlen   <= axi_len(w_win_type, LINE_WORDS);
            r_arsize  <= axi_size(w_win_type);
            r_rr      <= (w_win == 4'(NUM_RD-1)) ? 4'd0 : w_win + 4'd1;
        end else if (i_arready) begin
            r_arvalid <= 1'b0;
        end
    end

    // Outstanding-read bit per port: set on grant, cleared by that port's last R beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (o_rd_rdy[i])
                    r_pend[i] <= 1'b1;
                else if (i_rvalid && i_rlast && (i_rid == 4'(i)))
                    r_pend[i] <= 1'b0;
            end
        end
    end

    // Route each R beat to the port named by its ID.
    always_comb begin
        o_ret_valid = '0;
        o_ret_last  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            o_ret_valid[i] = i_rvalid && (i_rid == 4'(i));
            o_ret_last[i]  = i_rvalid && i_rlast && (i_rid == 4'(i));
        end
    end

    assign o_ret_data = i_rdata;
    assign o_rready   = 1'b1;
    assign o_arid     = r_arid;
    assign o_araddr   = r_araddr;
    assign o_arlen    = r_arlen;
    assign o_arsize   = r_arsize;
    assign o_arvalid  = r_arvalid;
    assign o_arburst  = 2'b01;
    assign o_arlock   = 2'b00;
    assign o_arcache  = 4'b0000;
    assign o_arprot   = 3'b000;

    // ---------------- write FSM ----------------
    wstate_t     r_wstate;
    wstate_t     w_wstate_nxt;
    logic        r_awvalid;
    logic [31:0] r_awaddr;
    logic [7:0]  r_awlen;
    logic [2:0]  r_awsize;
    logic        r_wvalid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_wlast;
    logic [7:0]  r_beat;
    logic        r_bready;
    logic [7:0]  w_next_beat;
    logic [31:0] w_next_word;
    logic        w_aw_done;
    logic        w_w_done;

    assign w_aw_done   = !r_awvalid || i_awready;
    assign w_w_done    = !r_wvalid || (i_wready && r_wlast);
    assign w_pop       = (r_wstate == W_RESP) && i_bvalid;
    assign w_next_beat = r_beat + 8'd1;

    // Select the next data word of the head line.
    always_comb begin
        w_next_word = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (w_next_beat == 8'(k))
                w_next_word = w_head.data[32*k +: 32];
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state.
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (!w_q_empty)            w_wstate_nxt = W_SEND;
            W_SEND:  if (w_aw_done && w_w_done) w_wstate_nxt = W_RESP;
            W_RESP:  if (i_bvalid)              w_wstate_nxt = W_IDLE;
            default:                            w_wstate_nxt = W_IDLE;
        endcase
    end

    // AW/W/B channel registers driven from the head entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_wvalid  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
            r_beat    <= '0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (!w_q_empty) begin
                        r_awvalid <= 1'b1;
                        r_awaddr  <= w_head.addr;
                        r_awlen   <= axi_len(w_head.typ, LINE_WORDS);
                        r_awsize  <= axi_size(w_head.typ);
                        r_wvalid  <= 1'b1;
                        r_wdata   <= w_head.data[31:0];
                        r_wstrb   <= (w_head.typ == TYPE_LINE) ? 4'hF : w_head.wstrb;
                        r_wlast   <= (axi_len(w_head.typ, LINE_WORDS) == 8'd0);
                        r_beat    <= '0;
                    end
                end
                W_SEND: begin
                    if (r_awvalid && i_awready)
                        r_awvalid <= 1'b0;
                    if (r_wvalid && i_wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                        end else begin
                            r_beat  <= w_next_beat;
                            r_wdata <= w_next_word;
                            r_wlast <= (w_next_beat == r_awlen);
                        end
                    end
                    if (w_aw_done && w_w_done)
                        r_bready <= 1'b1;
                end
                W_RESP: begin
                    if (i_bvalid)
                        r_bready <= 1'b0;
                end
                default: r_bready <= 1'b0;
            endcase
        end
    end

    assign o_awid    = 4'(NUM_RD);
    assign o_wid     = 4'(NUM_RD);
    assign o_awaddr  = r_awaddr;
    assign o_awlen   = r_awlen;
    assign o_awsize  = r_awsize;
    assign o_awvalid = r_awvalid;
    assign o_awburst = 2'b01;
    assign o_awlock  = 2'b00;
    assign o_awcache = 4'b0000;
    assign o_awprot  = 3'b000;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_wlast   = r_wlast;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;

    // Responses codes and IDs are not acted on; head bits beyond the line are never used.
    logic w_unused;
    assign w_unused = ^{i_rresp, i_bid, i_bresp, w_head, w_q_addr};

endmodule

// File: tb/tb_axi_bridge_mp.sv
// tb/tb_axi_bridge_mp.sv - scoreboard bench for axi_bridge_mp
module tb_axi_bridge_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic [1:0] arlock; logic [3:0] arcache; logic [2:0] arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp; logic rlast, rvalid, rready;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic [1:0] awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb; logic wlast, wvalid, wready;
    logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid, bready;
    logic [1:0]  rd_req; logic [5:0]  rd_type; logic [63:0] rd_addr;
    logic [1:0]  rd_rdy, ret_valid, ret_last; logic [31:0] ret_data;
    logic        wr_req; logic [2:0] wr_type; logic [31:0] wr_addr; logic [3:0] wr_wstrb;
    logic [127:0] wr_data;
    logic        wr_rdy, wbe;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [1:0] v; logic [1:0] l; logic [31:0] d; } rbeat_t;
    typedef struct { logic [31:0] d; logic [3:0] s; logic l; } wbeat_t;
    typedef struct { logic [3:0] id; logic [31:0] a; } ar_t;
    rbeat_t r_q[$];
    wbeat_t w_q[$];
    ar_t    ar_q[$];

    always #5 clk = ~clk;

    axi_bridge_mp #(.NUM_RD(2), .LINE_WORDS(4), .WQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
        .o_arburst(arburst), .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot),
        .o_arvalid(arvalid), .i_arready(arready),
        .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid),
        .o_rready(rready),
        .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
        .o_awburst(awburst), .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot),
        .o_awvalid(awvalid), .i_awready(awready),
        .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
        .i_wready(wready),
        .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
        .i_rd_req(rd_req), .i_rd_type(rd_type), .i_rd_addr(rd_addr), .o_rd_rdy(rd_rdy),
        .o_ret_valid(ret_valid), .o_ret_last(ret_last), .o_ret_data(ret_data),
        .i_wr_req(wr_req), .i_wr_type(wr_type), .i_wr_addr(wr_addr), .i_wr_wstrb(wr_wstrb),
        .i_wr_data(wr_data), .o_wr_rdy(wr_rdy), .o_write_buffer_empty(wbe)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        rd_req = 0; rd_type = 0; rd_addr = 0;
        wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
        r_q.delete(); w_q.delete(); ar_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        n_vec++;
        if ({arvalid, awvalid, wvalid, wlast, bready} !== 5'b0) begin
            n_err++; $display("FAIL reset_valids: got %b want 00000", {arvalid, awvalid, wvalid, wlast, bready});
        end
        n_vec++;
        if ({wr_rdy, wbe, rready} !== 3'b111) begin
            n_err++; $display("FAIL reset_status: got %b want 111", {wr_rdy, wbe, rready});
        end
        n_vec++;
        if ({arburst, awburst, awid, wid, arlock, arcache, arprot} !== {2'b01, 2'b01, 4'd2, 4'd2, 2'b0, 4'b0, 3'b0}) begin
            n_err++; $display("FAIL reset_consts: got %h/%h/%h/%h want 1/1/2/2", arburst, awburst, awid, wid);
        end
        n_vec++;
        if (rd_rdy !== 2'b00) begin
            n_err++; $display("FAIL reset_rdrdy: got %b want 00", rd_rdy);
        end
    endtask

    task automatic test_line_read;
        rbeat_t e;
        do_reset;
        @(negedge clk);
        rd_req = 2'b01; rd_type = {3'd0, 3'd4}; rd_addr = {32'h0, 32'h0000_1000}; arready = 0;
        #1;
        n_vec++;
        if (rd_rdy !== 2'b01) begin n_err++; $display("FAIL lr_grant: got %b want 01", rd_rdy); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rd_req = 2'b00; arready = (c == 2);
            #1;
            n_vec++;
            if ({arvalid, arid, araddr, arlen, arsize} !== {1'b1, 4'd0, 32'h0000_1000, 8'd3, 3'd2}) begin
                n_err++; $display("FAIL lr_ar_hold: cycle %0d got v%b id%h a%h len%h sz%h want v1 id0 a00001000 len03 sz2",
                                  c, arvalid, arid, araddr, arlen, arsize);
            end
        end
        @(negedge clk);
        arready = 0;
        #1;
        n_vec++;
        if (arvalid !== 1'b0) begin n_err++; $display("FAIL lr_ar_drop: got %b want 0", arvalid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rvalid = 1; rid = 0; rdata = 32'hD000_0000 + k; rlast = (k == 3);
            r_q.push_back('{v: 2'b01, l: (k == 3) ? 2'b01 : 2'b00, d: 32'hD000_0000 + k});
            #1;
            e = r_q.pop_front();
            n_vec++;
            if ({ret_valid, ret_last, ret_data} !== {e.v, e.l, e.d}) begin
                n_err++; $display("FAIL lr_beat%0d: got v%b l%b d%h want v%b l%b d%h",
                                  k, ret_valid, ret_last, ret_data, e.v, e.l, e.d);
            end
        end
        @(negedge clk);
        rvalid = 0; rlast = 0; rd_req = 2'b01;
        #1;
        n_vec++;
        if ({ret_valid, rd_rdy} !== 4'b0001) begin
            n_err++; $display("FAIL lr_regrant: got ret%b rdy%b want ret00 rdy01", ret_valid, rd_rdy);
        end
        @(negedge clk);
        rd_req = 2'b00;
    endtask

    task automatic test_round_robin;
        logic [1:0] g_exp [8] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        int         r_drv [8] = '{-1, -1, 0, 1, 0, 1, -1, -1};
        ar_t        a;
        rbeat_t     e;
        do_reset;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            arready = 1;
            rd_req = (c < 8) ? 2'b11 : 2'b00;
            rd_type = {3'd2, 3'd2}; rd_addr = {32'h0000_6000, 32'h0000_5000};
            rvalid = 0; rlast = 0; rid = 0;
            if (c < 8 && r_drv[c] >= 0) begin
                rvalid = 1; rlast = 1; rid = 4'(r_drv[c]); rdata = 32'h5500_0000 + c;
                r_q.push_back('{v: (r_drv[c] == 0) ? 2'b01 : 2'b10, l: (r_drv[c] == 0) ? 2'b01 : 2'b10,
                                d: 32'h5500_0000 + c});
            end
            #1;
            n_vec++;
            if (ar_q.size() > 0) begin
                a = ar_q.pop_front();
                if ({arvalid, arid, araddr} !== {1'b1, a.id, a.a}) begin
                    n_err++; $display("FAIL rr_ar: cycle %0d got v%b id%h a%h want v1 id%h a%h",
                                      c, arvalid, arid, araddr, a.id, a.a);
                end
            end else if (arvalid !== 1'b0) begin
                n_err++; $display("FAIL rr_ar_idle: cycle %0d got %b want 0", c, arvalid);
            end
            if (c < 8) begin
                n_vec++;
                if (rd_rdy !== g_exp[c]) begin
                    n_err++; $display("FAIL rr_grant: cycle %0d got %b want %b", c, rd_rdy, g_exp[c]);
                end
                if (g_exp[c] == 2'b01) ar_q.push_back('{id: 4'd0, a: 32'h0000_5000});
                if (g_exp[c] == 2'b10) ar_q.push_back('{id: 4'd1, a: 32'h0000_6000});
                n_vec++;
                if (r_drv[c] >= 0) begin
                    e = r_q.pop_front();
                    if ({ret_valid, ret_last, ret_data} !== {e.v, e.l, e.d}) begin
                        n_err++; $display("FAIL rr_ret: cycle %0d got v%b l%b d%h want v%b l%b d%h",
                                          c, ret_valid, ret_last, ret_data, e.v, e.l, e.d);
                    end
                end else if (ret_valid !== 2'b00) begin
                    n_err++; $display("FAIL rr_ret_idle: cycle %0d got %b want 00", c, ret_valid);
                end
            end
        end
        @(negedge clk);
        rvalid = 0; rlast = 0; rd_req = 0;
    endtask

    task automatic test_line_write;
        wbeat_t e;
        logic   tog = 1'b0;
        logic   aw_seen = 1'b0;
        logic   done = 1'b0;
        do_reset;
        @(negedge clk);
        wr_req = 1; wr_type = 3'd4; wr_addr = 32'h0000_2000; wr_wstrb = 4'h0;
        wr_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        #1;
        n_vec++;
        if ({wr_rdy, wbe} !== 2'b11) begin n_err++; $display("FAIL lw_pre: got %b want 11", {wr_rdy, wbe}); end
        w_q.push_back('{d: 32'hAAAA_0000, s: 4'hF, l: 1'b0});
        w_q.push_back('{d: 32'hBBBB_0001, s: 4'hF, l: 1'b0});
        w_q.push_back('{d: 32'hCCCC_0002, s: 4'hF, l: 1'b0});
        w_q.push_back('{d: 32'hDDDD_0003, s: 4'hF, l: 1'b1});
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            wr_req = 0; awready = 1;
            wready = wvalid && tog;
            if (wvalid) tog = ~tog;
            bvalid = bready;
            #1;
            if (awvalid && awready) begin
                aw_seen = 1'b1;
                n_vec++;
                if ({awaddr, awlen, awsize} !== {32'h0000_2000, 8'd3, 3'd2}) begin
                    n_err++; $display("FAIL lw_aw: got a%h len%h sz%h want a00002000 len03 sz2", awaddr, awlen, awsize);
                end
            end
            if (wvalid && wready) begin
                n_vec++;
                if (w_q.size() == 0) begin
                    n_err++; $display("FAIL lw_extra_beat: got d%h want no beat", wdata);
                end else begin
                    e = w_q.pop_front();
                    if ({wdata, wstrb, wlast} !== {e.d, e.s, e.l}) begin
                        n_err++; $display("FAIL lw_wbeat: got d%h s%h l%b want d%h s%h l%b",
                                          wdata, wstrb, wlast, e.d, e.s, e.l);
                    end
                end
            end
            if (bvalid && bready) begin
                done = 1'b1;
                n_vec++;
                if ({aw_seen, w_q.size() == 0, wbe} !== 3'b110) begin
                    n_err++; $display("FAIL lw_bresp: got aw%b wdone%b wbe%b want aw1 wdone1 wbe0",
                                      aw_seen, w_q.size() == 0, wbe);
                end
            end
        end
        n_vec++;
        if (!done) begin n_err++; $display("FAIL lw_timeout: got no B handshake want one"); end
        @(negedge clk);
        bvalid = 0; wready = 0;
        #1;
        n_vec++;
        if ({wbe, bready} !== 2'b10) begin n_err++; $display("FAIL lw_empty: got wbe%b bready%b want wbe1 bready0", wbe, bready); end
    endtask

    task automatic test_hazard;
        wbeat_t e;
        logic   b_seen = 1'b0;
        logic   granted = 1'b0;
        do_reset;
        @(negedge clk);
        wr_req = 1; wr_type = 3'd2; wr_addr = 32'h0000_3000; wr_wstrb = 4'h3;
        wr_data = {96'h0, 32'h1234_5678};
        rd_req = 2'b11; rd_type = {3'd2, 3'd2}; rd_addr = {32'h0000_3004, 32'h0000_4000};
        arready = 1; awready = 1; wready = 1;
        w_q.push_back('{d: 32'h1234_5678, s: 4'h3, l: 1'b1});
        #1;
        n_vec++;
        if (rd_rdy !== 2'b01) begin n_err++; $display("FAIL hz_first: got %b want 01", rd_rdy); end
        for (int c = 0; c < 30 && !granted; c++) begin
            @(negedge clk);
            wr_req = 0;
            bvalid = bready;
            #1;
            if (wvalid && wready) begin
                e = w_q.pop_front();
                n_vec++;
                if ({awlen, awsize, wdata, wstrb, wlast} !== {8'd0, 3'd2, e.d, e.s, e.l}) begin
                    n_err++; $display("FAIL hz_wbeat: got len%h sz%h d%h s%h l%b want len00 sz2 d%h s%h l%b",
                                      awlen, awsize, wdata, wstrb, wlast, e.d, e.s, e.l);
                end
            end
            n_vec++;
            if (!b_seen) begin
                if (rd_rdy !== 2'b00) begin n_err++; $display("FAIL hz_blocked: cycle %0d got %b want 00", c, rd_rdy); end
            end else begin
                granted = 1'b1;
                if (rd_rdy !== 2'b10) begin n_err++; $display("FAIL hz_release: got %b want 10", rd_rdy); end
            end
            if (bvalid && bready) b_seen = 1'b1;
        end
        n_vec++;
        if (!granted) begin n_err++; $display("FAIL hz_timeout: got no release want grant to port 1"); end
        @(negedge clk);
        rd_req = 0; bvalid = 0;
    endtask

    task automatic test_queue_full;
        logic seen = 1'b0;
        logic took = 1'b0;
        int   nb = 0;
        do_reset;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wr_req = 1; wr_type = 3'd2; wr_addr = 32'h0000_8000 + 32'(k * 64); wr_wstrb = 4'hF;
            wr_data = {96'h0, 32'hF000_0000 + 32'(k)};
            #1;
            n_vec++;
            if (wr_rdy !== (k < 4)) begin n_err++; $display("FAIL qf_rdy%0d: got %b want %b", k, wr_rdy, (k < 4)); end
        end
        for (int c = 0; c < 30 && !took; c++) begin
            @(negedge clk);
            awready = 1; wready = 1; bvalid = bready;
            #1;
            if (bvalid && bready) begin
                seen = 1'b1; nb++;
                n_vec++;
                if (wr_rdy !== 1'b0) begin n_err++; $display("FAIL qf_bcycle: got %b want 0", wr_rdy); end
            end else if (seen) begin
                took = 1'b1;
                n_vec++;
                if (wr_rdy !== 1'b1) begin n_err++; $display("FAIL qf_after_b: got %b want 1", wr_rdy); end
            end
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            wr_req = 0; bvalid = bready;
            #1;
            if (bvalid && bready) nb++;
            if (wbe && !bready) break;
        end
        n_vec++;
        if (nb !== 5) begin n_err++; $display("FAIL qf_bcount: got %0d want 5", nb); end
        @(negedge clk);
        bvalid = 0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        @(negedge clk);
        wr_req = 1; wr_type = 3'd4; wr_addr = 32'h0000_9000;
        wr_data = {32'h4, 32'h3, 32'h2, 32'h1};
        rd_req = 2'b01; rd_type = {3'd0, 3'd4}; rd_addr = {32'h0, 32'h0000_A000};
        arready = 0; awready = 1; wready = 1;
        @(negedge clk);
        wr_req = 0; rd_req = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if ({arvalid, wvalid, wbe} !== 3'b110) begin
            n_err++; $display("FAIL rm_pre: got ar%b w%b wbe%b want ar1 w1 wbe0", arvalid, wvalid, wbe);
        end
        reset = 1;
        @(negedge clk);
        #1;
        n_vec++;
        if ({arvalid, awvalid, wvalid, wlast, bready, wbe, wr_rdy} !== 7'b0000011) begin
            n_err++; $display("FAIL rm_post: got %b want 0000011", {arvalid, awvalid, wvalid, wlast, bready, wbe, wr_rdy});
        end
        reset = 0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset;
        test_line_read;
        test_round_robin;
        test_line_write;
        test_hazard;
        test_queue_full;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
